// File: rtl/aux_ade_sched_pkg.sv
// Shared constants, header/payload field helpers and state encoding for the aux
// data-island scheduler.
package aux_ade_sched_pkg;

  localparam int unsigned BURST_LEN = 32;
  localparam int unsigned HCNT_W    = 11;
  localparam int unsigned IDX_W     = $clog2(BURST_LEN);
  localparam int unsigned HPOS_W    = 12;
  localparam int unsigned DATA_W    = 12;
  localparam int unsigned WORD_W    = 24;
  localparam int unsigned NUM_W     = 4;

  localparam logic [HPOS_W-1:0] SKIP_HPOS = 12'hFFF;

  localparam int unsigned HDR_MSB = 23;
  localparam int unsigned HDR_LSB = 12;
  localparam int unsigned PAY_MSB = 11;
  localparam int unsigned PAY_LSB = 0;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPrime = 3'd1,
    StArmed = 3'd2,
    StBurst = 3'd3,
    StFetch = 3'd4
  } state_e;

  function automatic logic [HPOS_W-1:0] hdr_hpos(input logic [WORD_W-1:0] word);
    return word[HDR_MSB:HDR_LSB];
  endfunction

  function automatic logic [DATA_W-1:0] pay_data(input logic [WORD_W-1:0] word);
    return word[PAY_MSB:PAY_LSB];
  endfunction

endpackage

// File: rtl/aux_ade_sched_edge_det.sv
// Registered rising-edge detector: o_rise is high in the first cycle i_sig is high.
module aux_ade_sched_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/aux_ade_sched.sv
// Pops an hpos header from the aux FIFO, waits for that position in blanking and
// streams one BURST_LEN-word data-island burst; counts bursts per line.
module aux_ade_sched
  import aux_ade_sched_pkg::*;
(
  input  logic                fifo_clk,
  input  logic                sys_rst,
  input  logic [HCNT_W-1:0]   hcnt,
  input  logic                vde,
  input  logic [WORD_W-1:0]   ax_dout,
  input  logic                ax_empty,
  output logic                ax_rd_en,
  output logic                ade,
  output logic [DATA_W-1:0]   ade_data,
  output logic [NUM_W-1:0]    ade_num,
  output logic                underflow
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [HPOS_W-1:0]   r_hpos;
  logic [IDX_W-1:0]    r_idx;
  logic                r_ade;
  logic                r_rd_issued;
  logic                r_underflow;
  logic [NUM_W-1:0]    r_cnt;
  logic [NUM_W-1:0]    r_num;

  logic                w_match;
  logic                w_slot;
  logic                w_burst_done;
  logic                w_vde_rise;
  logic [NUM_W-1:0]    w_cnt_inc;

  aux_ade_sched_edge_det u_vde_edge (
    .i_clk   (fifo_clk),
    .i_rst_n (sys_rst),
    .i_sig   (vde),
    .o_rise  (w_vde_rise)
  );

  assign w_match = !vde && ({1'b0, hcnt} == r_hpos);

  // w_slot marks a payload read slot; the first one is the match cycle itself.
  always_comb begin
    w_state_nxt = r_state;
    ax_rd_en    = 1'b0;
    w_slot      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!ax_empty) begin
          ax_rd_en    = 1'b1;
          w_state_nxt = StPrime;
        end
      end
      StPrime: begin
        w_state_nxt = (hdr_hpos(ax_dout) == SKIP_HPOS) ? StIdle : StArmed;
      end
      StArmed: begin
        if (w_match) begin
          w_slot      = 1'b1;
          ax_rd_en    = !ax_empty;
          w_state_nxt = StBurst;
        end
      end
      StBurst: begin
        w_slot   = 1'b1;
        ax_rd_en = !ax_empty;
        if (r_idx == IDX_W'(BURST_LEN - 1)) begin
          w_state_nxt = StFetch;
        end
      end
      StFetch: begin
        if (!ax_empty) begin
          ax_rd_en    = 1'b1;
          w_state_nxt = StPrime;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge fifo_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= StIdle;
      r_hpos  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StPrime) begin
        r_hpos <= hdr_hpos(ax_dout);
      end
      r_idx <= w_slot ? r_idx + 1'b1 : '0;
    end
  end

  // A skipped read keeps its ade slot but carries zero data and flags underflow.
  always_ff @(posedge fifo_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_ade       <= 1'b0;
      r_rd_issued <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_ade       <= w_slot;
      r_rd_issued <= w_slot && !ax_empty;
      r_underflow <= r_underflow | (w_slot & ax_empty);
    end
  end

  // FETCH coincides with the last ade cycle of a burst.
  assign w_burst_done = (r_state == StFetch);
  assign w_cnt_inc    = (r_cnt == {NUM_W{1'b1}}) ? r_cnt : r_cnt + NUM_W'(w_burst_done);

  always_ff @(posedge fifo_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt <= '0;
      r_num <= '0;
    end else if (w_vde_rise) begin
      r_num <= w_cnt_inc;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

  // The FIFO read port is registered, so gating its output keeps ade_data aligned with ade.
  assign ade_data  = r_rd_issued ? pay_data(ax_dout) : '0;
  assign ade       = r_ade;
  assign ade_num   = r_num;
  assign underflow = r_underflow;

endmodule
